// File: rtl/freq_ratio_meter.sv
// Measures period and high time of a divided waveform synchronous to i_clk,
// with lock detection over repeated equal periods and a sticky no-edge timeout.
module freq_ratio_meter #(
   parameter int unsigned CNT_W    = 16,
   parameter int unsigned LOCK_CNT = 4
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_en,
   input  logic             i_sig,
   output logic [CNT_W-1:0] o_period,
   output logic [CNT_W-1:0] o_high,
   output logic             o_valid,
   output logic             o_locked,
   output logic             o_timeout
);

   localparam int unsigned MatchW = (LOCK_CNT > 2) ? $clog2(LOCK_CNT) : 1;
   localparam logic [CNT_W-1:0]  CntMax   = '1;
   localparam logic [CNT_W-1:0]  CntOne   = CNT_W'(1);
   localparam logic [MatchW-1:0] MatchMax = MatchW'(LOCK_CNT - 1);
   localparam logic [MatchW-1:0] MatchOne = MatchW'(1);

   typedef enum logic [1:0] {StIdle, StArm, StMeasure} state_e;

   state_e            state_q, state_d;
   logic              sig_q, sig_d;
   logic [CNT_W-1:0]  per_cnt_q, per_cnt_d;
   logic [CNT_W-1:0]  hi_cnt_q, hi_cnt_d;
   logic [MatchW-1:0] match_cnt_q, match_cnt_d;
   logic              first_q, first_d;
   logic [CNT_W-1:0]  period_q, period_d;
   logic [CNT_W-1:0]  high_q, high_d;
   logic              valid_q, valid_d;
   logic              locked_q, locked_d;
   logic              timeout_q, timeout_d;

   logic rise;
   logic active;
   logic capture;
   logic timeout_evt;

   assign rise        = i_sig & ~sig_q;
   assign active      = i_en & ((state_q == StArm) | (state_q == StMeasure));
   assign capture     = i_en & (state_q == StMeasure) & rise;
   // Fires once, on the cycle per_cnt would step onto its saturated value.
   assign timeout_evt = active & ~rise & (per_cnt_q == (CntMax - CntOne));
   assign sig_d       = i_sig;

   // State register and datapath flops
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q     <= StIdle;
         sig_q       <= 1'b0;
         per_cnt_q   <= '0;
         hi_cnt_q    <= '0;
         match_cnt_q <= '0;
         first_q     <= 1'b0;
         period_q    <= '0;
         high_q      <= '0;
         valid_q     <= 1'b0;
         locked_q    <= 1'b0;
         timeout_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         sig_q       <= sig_d;
         per_cnt_q   <= per_cnt_d;
         hi_cnt_q    <= hi_cnt_d;
         match_cnt_q <= match_cnt_d;
         first_q     <= first_d;
         period_q    <= period_d;
         high_q      <= high_d;
         valid_q     <= valid_d;
         locked_q    <= locked_d;
         timeout_q   <= timeout_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      if (!i_en) begin
         state_d = StIdle;
      end else begin
         unique case (state_q)
            StIdle:    state_d = StArm;
            StArm:     if (rise) state_d = StMeasure;
            StMeasure: if (timeout_evt) state_d = StArm;
            default:   state_d = StIdle;
         endcase
      end
   end

   // Period and high-time counters
   always_comb begin
      per_cnt_d = per_cnt_q;
      hi_cnt_d  = hi_cnt_q;
      if (!active) begin
         per_cnt_d = '0;
         hi_cnt_d  = '0;
      end else if (rise) begin
         per_cnt_d = CntOne;
         hi_cnt_d  = CntOne;
      end else begin
         if (per_cnt_q != CntMax) per_cnt_d = per_cnt_q + CntOne;
         if (i_sig && (hi_cnt_q != CntMax)) hi_cnt_d = hi_cnt_q + CntOne;
      end
   end

   // Capture, lock and timeout outputs
   always_comb begin
      period_d    = period_q;
      high_d      = high_q;
      valid_d     = 1'b0;
      locked_d    = locked_q;
      timeout_d   = timeout_q;
      match_cnt_d = match_cnt_q;
      first_d     = first_q;
      if (!i_en) begin
         locked_d    = 1'b0;
         match_cnt_d = '0;
      end else if (active) begin
         if (rise) begin
            timeout_d = 1'b0;
            if (!capture) begin
               first_d = 1'b1;
            end else begin
               period_d = per_cnt_q;
               high_d   = hi_cnt_q;
               valid_d  = 1'b1;
               first_d  = 1'b0;
               // The first capture after arming has nothing to compare against.
               if (first_q || (per_cnt_q != period_q)) begin
                  match_cnt_d = '0;
                  locked_d    = 1'b0;
               end else if (match_cnt_q == MatchMax) begin
                  locked_d = 1'b1;
               end else begin
                  match_cnt_d = match_cnt_q + MatchOne;
                  if (match_cnt_q == (MatchMax - MatchOne)) locked_d = 1'b1;
               end
            end
         end else if (timeout_evt) begin
            timeout_d   = 1'b1;
            locked_d    = 1'b0;
            match_cnt_d = '0;
         end
      end
   end

   assign o_period  = period_q;
   assign o_high    = high_q;
   assign o_valid   = valid_q;
   assign o_locked  = locked_q;
   assign o_timeout = timeout_q;

endmodule

// File: tb/tb_freq_ratio_meter.sv
// Bench for freq_ratio_meter: directed scenarios plus random waveforms, checked
// every cycle against a window/queue based reference model.
module tb_freq_ratio_meter;

   localparam int unsigned CW   = 4;
   localparam int unsigned LK   = 4;
   localparam int          MAXV = 15;

   logic          clk = 1'b0;
   logic          rst_r, en_r, sig_r;
   logic [CW-1:0] o_period, o_high;
   logic          o_valid, o_locked, o_timeout;

   always #5 clk = ~clk;

   freq_ratio_meter #(
      .CNT_W   (CW),
      .LOCK_CNT(LK)
   ) dut (
      .i_clk    (clk),
      .i_rst    (rst_r),
      .i_en     (en_r),
      .i_sig    (sig_r),
      .o_period (o_period),
      .o_high   (o_high),
      .o_valid  (o_valid),
      .o_locked (o_locked),
      .o_timeout(o_timeout)
   );

   int checks = 0;
   int errors = 0;

   // Reference model: mode 0 idle, 1 waiting for first edge, 2 measuring.
   int            m_mode = 0;
   bit            m_prev = 1'b0;
   bit            win[$];
   int            caps[$];
   logic [CW-1:0] m_period = '0, m_high = '0;
   bit            m_valid = 1'b0, m_locked = 1'b0, m_timeout = 1'b0;

   int per_g = 4, hi_g = 2, ph = 0;

   function automatic bit locked_from_caps();
      int n = caps.size();
      if (n < int'(LK)) return 1'b0;
      for (int i = n - int'(LK); i < n; i++) if (caps[i] != caps[n-1]) return 1'b0;
      return 1'b1;
   endfunction

   task automatic model_step(input bit rst, input bit en, input bit s);
      bit rise = s && !m_prev;
      int n, h;
      m_valid = 1'b0;
      if (rst) begin
         m_mode = 0; m_prev = 1'b0; win.delete(); caps.delete();
         m_period = '0; m_high = '0; m_locked = 1'b0; m_timeout = 1'b0;
         return;
      end
      if (!en) begin
         m_mode = 0; caps.delete(); win.delete(); m_locked = 1'b0;
      end else if (m_mode == 0) begin
         m_mode = 1; win.delete();
      end else if (rise) begin
         if (m_mode == 2) begin
            n = win.size(); h = 0;
            foreach (win[i]) h += int'(win[i]);
            m_period = CW'((n > MAXV) ? MAXV : n);
            m_high   = CW'((h > MAXV) ? MAXV : h);
            m_valid  = 1'b1;
            caps.push_back(n);
            m_locked = locked_from_caps();
         end else begin
            caps.delete();
         end
         m_mode = 2; m_timeout = 1'b0;
         win.delete(); win.push_back(1'b1);
      end else begin
         if (win.size() == MAXV - 1) begin
            m_timeout = 1'b1; m_locked = 1'b0; caps.delete(); m_mode = 1;
         end
         win.push_back(s);
      end
      m_prev = s;
   endtask

   task automatic step(input bit rst, input bit en, input bit s);
      rst_r = rst; en_r = en; sig_r = s;
      @(posedge clk);
      model_step(rst, en, s);
      #1;
   endtask

   task automatic next_bit(output bit b);
      b  = (ph < hi_g);
      ph = (ph + 1) % per_g;
   endtask

   function automatic logic [10:0] obs();
      return {o_period, o_high, o_valid, o_locked, o_timeout};
   endfunction

   function automatic logic [10:0] expv();
      return {m_period, m_high, m_valid, m_locked, m_timeout};
   endfunction

   task automatic test_reset();
      step(1'b1, 1'b1, 1'b1);
      step(1'b1, 1'b1, 1'b1);
      checks++;
      if (obs() !== 11'h0) begin
         errors++;
         $display("FAIL reset_outputs: got %h want %h", obs(), 11'h0);
      end
      step(1'b0, 1'b0, 1'b0);
   endtask

   task automatic test_div4();
      bit s;
      per_g = 4; hi_g = 2; ph = 0;
      for (int i = 0; i < 40; i++) begin
         next_bit(s); step(1'b0, 1'b1, s);
         checks++;
         if (obs() !== expv()) begin
            errors++;
            $display("FAIL div4 cyc %0d: got %h want %h", i, obs(), expv());
         end
      end
      checks++;
      if ({o_period, o_high, o_locked} !== {4'd4, 4'd2, 1'b1}) begin
         errors++;
         $display("FAIL div4_final: got p=%0d h=%0d l=%0b want p=4 h=2 l=1",
                  o_period, o_high, o_locked);
      end
   endtask

   task automatic test_div5_div6();
      bit s;
      per_g = 5; hi_g = 3; ph = 0;
      for (int i = 0; i < 80; i++) begin
         if (i == 40) begin per_g = 6; ph = 0; end
         next_bit(s); step(1'b0, 1'b1, s);
         checks++;
         if (obs() !== expv()) begin
            errors++;
            $display("FAIL div5_6 cyc %0d: got %h want %h", i, obs(), expv());
         end
      end
      checks++;
      if ({o_period, o_high, o_locked} !== {4'd6, 4'd3, 1'b1}) begin
         errors++;
         $display("FAIL div6_final: got p=%0d h=%0d l=%0b want p=6 h=3 l=1",
                  o_period, o_high, o_locked);
      end
   endtask

   task automatic test_timeout();
      bit s;
      per_g = 4; hi_g = 2; ph = 0;
      for (int i = 0; i < 60; i++) begin
         if (i < 24 || i >= 44) next_bit(s);
         else s = 1'b0;
         if (i == 44) begin ph = 0; next_bit(s); end
         step(1'b0, 1'b1, s);
         checks++;
         if (obs() !== expv()) begin
            errors++;
            $display("FAIL timeout cyc %0d: got %h want %h", i, obs(), expv());
         end
         if (i == 43) begin
            checks++;
            if ({o_timeout, o_locked} !== 2'b10) begin
               errors++;
               $display("FAIL timeout_set: got to=%0b l=%0b want to=1 l=0", o_timeout, o_locked);
            end
         end
      end
      checks++;
      if ({o_timeout, o_period} !== {1'b0, 4'd4}) begin
         errors++;
         $display("FAIL timeout_recover: got to=%0b p=%0d want to=0 p=4", o_timeout, o_period);
      end
   endtask

   task automatic test_en_drop();
      bit s;
      per_g = 4; hi_g = 2; ph = 0;
      for (int i = 0; i < 30; i++) begin next_bit(s); step(1'b0, 1'b1, s); end
      while (ph != 0) begin next_bit(s); step(1'b0, 1'b1, s); end
      next_bit(s);
      step(1'b0, 1'b0, s);
      checks++;
      if ({o_valid, o_locked, o_period} !== {1'b0, 1'b0, 4'd4}) begin
         errors++;
         $display("FAIL en_drop: got v=%0b l=%0b p=%0d want v=0 l=0 p=4",
                  o_valid, o_locked, o_period);
      end
      for (int i = 0; i < 36; i++) begin
         next_bit(s); step(1'b0, (i >= 5), s);
         checks++;
         if (obs() !== expv()) begin
            errors++;
            $display("FAIL reenable cyc %0d: got %h want %h", i, obs(), expv());
         end
      end
   endtask

   task automatic test_rst_mid();
      bit s;
      per_g = 4; hi_g = 2; ph = 0;
      for (int i = 0; i < 20; i++) begin next_bit(s); step(1'b0, 1'b1, s); end
      while (ph != 2) begin next_bit(s); step(1'b0, 1'b1, s); end
      next_bit(s);
      step(1'b1, 1'b1, s);
      checks++;
      if (obs() !== 11'h0) begin
         errors++;
         $display("FAIL rst_mid: got %h want %h", obs(), 11'h0);
      end
      for (int i = 0; i < 30; i++) begin
         next_bit(s); step(1'b0, 1'b1, s);
         checks++;
         if (obs() !== expv()) begin
            errors++;
            $display("FAIL rst_resume cyc %0d: got %h want %h", i, obs(), expv());
         end
      end
      checks++;
      if (o_locked !== 1'b1) begin
         errors++;
         $display("FAIL rst_relock: got %0b want 1", o_locked);
      end
   endtask

   task automatic test_div2();
      bit s;
      int nvalid = 0;
      per_g = 2; hi_g = 1; ph = 0;
      for (int i = 0; i < 30; i++) begin
         next_bit(s); step(1'b0, 1'b1, s);
         if (i >= 20) nvalid += int'(o_valid);
         checks++;
         if (obs() !== expv()) begin
            errors++;
            $display("FAIL div2 cyc %0d: got %h want %h", i, obs(), expv());
         end
      end
      checks++;
      if ({o_period, o_high, nvalid} !== {4'd2, 4'd1, 32'd5}) begin
         errors++;
         $display("FAIL div2_final: got p=%0d h=%0d nv=%0d want p=2 h=1 nv=5",
                  o_period, o_high, nvalid);
      end
   endtask

   task automatic test_random();
      bit s, r, en_seg;
      int len;
      for (int seg = 0; seg < 30; seg++) begin
         len    = int'($urandom_range(40, 10));
         en_seg = ($urandom_range(9, 0) != 0);
         per_g  = int'($urandom_range(18, 2));
         hi_g   = int'($urandom_range(per_g - 1, 1));
         ph     = int'($urandom_range(per_g - 1, 0));
         for (int i = 0; i < len; i++) begin
            next_bit(s);
            r = ($urandom_range(99, 0) == 0);
            step(r, en_seg, s);
            checks++;
            if (obs() !== expv()) begin
               errors++;
               $display("FAIL random seg %0d cyc %0d (per %0d hi %0d): got %h want %h",
                        seg, i, per_g, hi_g, obs(), expv());
            end
         end
      end
   endtask

   initial begin
      rst_r = 1'b1; en_r = 1'b0; sig_r = 1'b0;
      test_reset();
      test_div4();
      test_div5_div6();
      test_timeout();
      test_en_drop();
      test_rst_mid();
      test_div2();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
